msg_streamer: RTL

Parametrised successor to the fixed hello-string loop: streams a terminator-ended byte message from a synchronous-read memory (BRAM1-style, 1-cycle read latency) to a byte sink (UART TX) over a valid/ready handshake. A start pulse with a base address launches a message. Capabilities:
- configurable data width and terminator value;
- length cap and byte counter;
- abort;
- busy/done status.
Sits between the SoC boot ROM and the UART, replacing ad-hoc stepping logic in the top level.

---
 rtl/msg_streamer_pkg.sv | 22 ++
 rtl/msg_streamer_if.sv | 23 ++
 rtl/msg_streamer.sv | 116 +++++++++++
 3 files changed

// File: rtl/msg_streamer_pkg.sv
// Shared types for the message streamer.
// FSM state encoding and the CR/LF line-ending characters.
package msg_streamer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CHECK,
        S_SEND,
        S_CR,
        S_LF,
        S_DONE
    } state_t;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    function automatic logic [7:0] crlf_char(input logic lf);
        return lf ? CHAR_LF : CHAR_CR;
    endfunction

endpackage

// File: rtl/msg_streamer_if.sv
// Memory read port plus byte-sink valid/ready stream.
// master = streamer side, slave = memory/sink side.
interface msg_streamer_if #(
    parameter int AddrWidth = 19,
    parameter int DataWidth = 8
);
    logic [AddrWidth-1:0] ADDR;
    logic                 RE;
    logic [DataWidth-1:0] RDATA;
    logic [DataWidth-1:0] TXDATA;
    logic                 TXVALID;
    logic                 TXREADY;

    modport master (
        output ADDR, RE, TXDATA, TXVALID,
        input  RDATA, TXREADY
    );

    modport slave (
        input  ADDR, RE, TXDATA, TXVALID,
        output RDATA, TXREADY
    );
endinterface

// File: rtl/msg_streamer.sv
// Streams a terminator-ended message from sync-read memory to a byte sink.
// Define MSG_STREAMER_CRLF_EN to append CR/LF after the terminator.
module msg_streamer
    import msg_streamer_pkg::*;
#(
    parameter int                   AddrWidth  = 19,
    parameter int                   DataWidth  = 8,
    parameter logic [DataWidth-1:0] Terminator = '0,
    parameter int                   MaxLen     = 1024,
    parameter int                   LenWidth   = 11
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [AddrWidth-1:0] BASE,
    input  logic                 ABORT,
    msg_streamer_if.master       bus,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 OVERRUN,
    output logic [LenWidth-1:0]  COUNT
);

`ifdef MSG_STREAMER_CRLF_EN
    localparam state_t TermNext = S_CR;
`else
    localparam state_t TermNext = S_DONE;
`endif

    state_t               state;
    state_t               state_n;
    logic [AddrWidth-1:0] addr_q;
    logic [DataWidth-1:0] txdata_q;
    logic [LenWidth-1:0]  count_q;
    logic [LenWidth-1:0]  count_inc;
    logic                 ovr_q;
    logic                 is_term;
    logic                 at_max;

    assign count_inc = count_q + LenWidth'(1);
    assign at_max    = (count_inc == LenWidth'(MaxLen));
    assign is_term   = (bus.RDATA == Terminator);

    assign bus.ADDR   = addr_q;
    assign bus.TXDATA = txdata_q;
    assign COUNT      = count_q;
    assign OVERRUN    = ovr_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        bus.RE      = (state == S_FETCH);
        bus.TXVALID = (state == S_SEND) || (state == S_CR) || (state == S_LF);
        BUSY        = (state != S_IDLE);
        DONE        = (state == S_DONE);
        // Abort outranks everything, including a START seen in IDLE.
        if (ABORT) begin
            state_n = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:  if (START) state_n = S_FETCH;
                S_FETCH: state_n = S_CHECK;
                S_CHECK: state_n = is_term ? TermNext : S_SEND;
                S_SEND: begin
                    if (bus.TXREADY) state_n = at_max ? S_DONE : S_FETCH;
                end
                S_CR:    if (bus.TXREADY) state_n = S_LF;
                S_LF:    if (bus.TXREADY) state_n = S_DONE;
                S_DONE:  state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q   <= '0;
            txdata_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
        end else if (!ABORT) begin
            if (state == S_IDLE && START) begin
                addr_q  <= BASE;
                count_q <= '0;
                ovr_q   <= 1'b0;
            end
            if (state == S_CHECK) begin
                if (!is_term) begin
                    txdata_q <= bus.RDATA;
                end
`ifdef MSG_STREAMER_CRLF_EN
                else begin
                    txdata_q <= DataWidth'(crlf_char(1'b0));
                end
`endif
            end
            if (state == S_SEND && bus.TXREADY) begin
                count_q <= count_inc;
                addr_q  <= addr_q + AddrWidth'(1);
                if (at_max) ovr_q <= 1'b1;
            end
            // Line-ending bytes bypass COUNT, ADDR and the length cap.
            if (state == S_CR && bus.TXREADY) begin
                txdata_q <= DataWidth'(crlf_char(1'b1));
            end
        end
    end

endmodule
